// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request and HI/LO/busy result bundle of the md unit.
// The master drives the request; the slave returns busy and the registers.
interface md_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit owning HI/LO for the E stage of the core.
// Optional MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res_q, res_d;
    logic        dz_q, dz_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] dvn;
    logic [31:0] dvs;
    logic [31:0] dvs_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    // Lower 64 bits of a sign-extended 64x64 product equal the signed 32x32 result.
    assign prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
    assign prod_u = {32'd0, md.a} * {32'd0, md.b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
    assign sdiv     = (md.op == OP_DIV);
    assign dvn      = (sdiv && md.a[31]) ? (32'd0 - md.a) : md.a;
    assign dvs      = (sdiv && md.b[31]) ? (32'd0 - md.b) : md.b;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign uq       = dvn / dvs_safe;
    assign ur       = dvn % dvs_safe;
    assign quo      = (sdiv && (md.a[31] ^ md.b[31])) ? (32'd0 - uq) : uq;
    assign rem      = (sdiv && md.a[31]) ? (32'd0 - ur) : ur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (md.start) begin
                    case (md.op)
                        OP_MULT: begin
                            res_d   = prod_s;
                            dz_d    = 1'b0;
                            cnt_d   = 5'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
                        OP_MULTU: begin
                            res_d   = prod_u;
                            dz_d    = 1'b0;
                            cnt_d   = 5'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_d   = {rem, quo};
                            dz_d    = (md.b == 32'd0);
                            cnt_d   = 5'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = md.a;
                        OP_MTLO: lo_d = md.a;
`ifdef MD_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            case (md.op)
                                OP_MADD:  res_d = {hi_q, lo_q} + prod_s;
                                OP_MADDU: res_d = {hi_q, lo_q} + prod_u;
                                OP_MSUB:  res_d = {hi_q, lo_q} - prod_s;
                                default:  res_d = {hi_q, lo_q} - prod_u;
                            endcase
                            dz_d    = 1'b0;
                            cnt_d   = 5'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    if (!dz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            res_q   <= 64'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execution unit in the E stage of the pipelined MIPS core.
- Owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo.
- Drives the `busy` signal consumed by the hazard logic, which stalls any D-stage md-class instruction while `busy` is high or while an md start sits in E.
- The M stage reads `hi`/`lo` for mfhi/mflo through the existing forwarding muxes.

Parameters:
- MULT_CYCLES, 5: number of busy cycles for mult/multu (and madd/msub variants); legal range 1..31.
- DIV_CYCLES, 10: number of busy cycles for div/divu; legal range 1..31.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  E-stage md instruction valid this cycle; qualifies op.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; other codes behave as NONE.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- busy  output  1  high while a mult/div is in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (async, reset=0): busy=0, hi=0, lo=0, state=IDLE, counter=0, pending result discarded. Takes effect immediately, including mid-operation.
- States: IDLE and BUSY; 5-bit down-counter cnt.
- IDLE, start=1, op in {MULT, MULTU, (MADD..MSUBU)}:
  - Compute the 64-bit result from a/b and latch it into shadow {res_hi, res_lo}.
  - Load cnt=MULT_CYCLES and go to BUSY.
- IDLE, start=1, op in {DIV, DIVU}: same, with cnt=DIV_CYCLES.
- IDLE, start=1, MTHI/MTLO: hi<=a (resp. lo<=a) at that edge. No busy, stays IDLE.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - hi<=res_hi and lo<=res_lo (unless divide-by-zero, see below);
  - go to IDLE with busy=0.
- Latency: with start sampled at edge t, busy=1 for exactly N cycles (edges t+1..t+N); new HI/LO is visible with busy=0 from edge t+N.
- busy is a registered output. It is low in the cycle start is presented; the hazard unit's E-stage md check covers that cycle.
- start while BUSY: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never happens; the bench flags it as an error.
- hi/lo hold their old values throughout BUSY.
- MULT: signed 32x32 to 64; hi = upper 32 bits, lo = lower 32 bits.
- MULTU: unsigned 32x32 to 64.
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend (a).
- Signed DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0):
  - busy still asserted for DIV_CYCLES;
  - hi/lo left unchanged at completion.
- op NONE or an undefined code with start=1: no effect.

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - MADD/MADDU: {hi,lo} <= {hi,lo} + product, where the product is signed for MADD and unsigned for MADDU, and {hi,lo} is sampled at start.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - product, with the same signedness rule and sampling.
  - All four use MULT_CYCLES latency and 64-bit wrap-around arithmetic.
- Not defined: op 7..10 decode as NONE (no busy, no state change).

Test Plan:
- Reset mid-op: MULT started, reset=0 at busy cycle 2 -> busy=0, hi=lo=0 immediately; no writeback after reset release.
- MULT a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 after MTHI 0x11 / MTLO 0x22 -> busy 10 cycles, then hi=0x11, lo=0x22.
- MTHI a=0xDEADBEEF -> hi=0xDEADBEEF one edge later, busy never rises. Back-to-back MTLO then MULT 3x4 -> lo=0x0C after 5 busy cycles.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Start pulse during BUSY with MTHI -> hi unchanged.
- (MD_MADD_EN) hi=0, lo=0xFFFFFFFF; MADDU 1x1 -> hi=1, lo=0. Then MSUB 1x1 -> hi=0, lo=0xFFFFFFFF. Without the macro, op 7 -> hi/lo unchanged, busy=0.
